// File: rtl/risc_pkg.sv
// Shared types and constants for the 16-bit pipelined processor.
package risc_pkg;

    localparam int DATA_W = 16;
    localparam int OPC_W  = 8;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    localparam logic [OPC_W-1:0] OP_NOP = 8'h00;
    localparam logic [OPC_W-1:0] OP_ADD = 8'h01;
    localparam logic [OPC_W-1:0] OP_SUB = 8'h02;
    localparam logic [OPC_W-1:0] OP_AND = 8'h03;
    localparam logic [OPC_W-1:0] OP_OR  = 8'h04;
    localparam logic [OPC_W-1:0] OP_XOR = 8'h05;
    localparam logic [OPC_W-1:0] OP_SHL = 8'h06;
    localparam logic [OPC_W-1:0] OP_SHR = 8'h07;
    localparam logic [OPC_W-1:0] OP_MUL = 8'h08;
    localparam logic [OPC_W-1:0] OP_JMP = 8'h10;
    localparam logic [OPC_W-1:0] OP_JZ  = 8'h11;
    localparam logic [OPC_W-1:0] OP_JC  = 8'h12;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } ex_state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// 16x16 shift-add multiplier: first partial product on start,
// remaining fifteen on the following edges; done while count is 15.
module shift_add_multiplier
    import risc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);

    logic                busy;
    logic [3:0]          count;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;

    assign done    = busy && (count == 4'd15);
    assign product = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            count  <= 4'd0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= 4'd0;
            acc    <= b[0] ? {16'h0000, a} : '0;
            mcand  <= {15'h0000, a, 1'b0};
            mplier <= {1'b0, b[DATA_W-1:1]};
        end else if (busy) begin
            if (count == 4'd15) begin
                busy <= 1'b0;
            end else begin
                count  <= count + 4'd1;
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= {mcand[2*DATA_W-2:0], 1'b0};
                mplier <= {1'b0, mplier[DATA_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Pipeline stage 3: single-cycle ALU, multi-cycle multiply and jump
// resolution, registering results into the stage-3/4 buffer.
module execute_stage
    import risc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] pc_in,
    output logic              stall,
    output logic              flush,
    output logic [DATA_W-1:0] branch_target,
    output logic              res_valid,
    output logic [DATA_W-1:0] result,
    output logic [OPC_W-1:0]  opcode_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [2:0]        flags
);

    ex_state_t state;
    logic [DATA_W-1:0] mul_pc;

    logic accept;
    logic is_mul;
    logic mul_done;
    logic [2*DATA_W-1:0] product;

    logic [DATA_W-1:0] alu_res;
    logic alu_c;
    logic upd_flags;
    logic taken;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic [3:0]      shamt;
    logic [4:0]      shl_idx;

    assign accept = in_valid && (state == IDLE) && !flush;
    assign is_mul = (opcode == OP_MUL);

    shift_add_multiplier u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (op1),
        .b       (op2),
        .done    (mul_done),
        .product (product)
    );

    assign sum     = {1'b0, op1} + {1'b0, op2};
    assign diff    = {1'b0, op1} - {1'b0, op2};
    assign shamt   = op2[3:0];
    assign shl_idx = 5'd16 - {1'b0, shamt};

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        upd_flags = 1'b0;
        taken     = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res   = sum[DATA_W-1:0];
                alu_c     = sum[DATA_W];
                upd_flags = 1'b1;
            end
            OP_SUB: begin
                alu_res   = diff[DATA_W-1:0];
                alu_c     = diff[DATA_W];
                upd_flags = 1'b1;
            end
            OP_AND: begin
                alu_res   = op1 & op2;
                upd_flags = 1'b1;
            end
            OP_OR: begin
                alu_res   = op1 | op2;
                upd_flags = 1'b1;
            end
            OP_XOR: begin
                alu_res   = op1 ^ op2;
                upd_flags = 1'b1;
            end
            OP_SHL: begin
                alu_res   = op1 << shamt;
                alu_c     = (shamt != 4'd0) && op1[shl_idx[3:0]];
                upd_flags = 1'b1;
            end
            OP_SHR: begin
                alu_res   = op1 >> shamt;
                alu_c     = (shamt != 4'd0) && op1[shamt - 4'd1];
                upd_flags = 1'b1;
            end
            OP_JMP: taken = 1'b1;
            OP_JZ:  taken = flags[FLAG_Z];
            OP_JC:  taken = flags[FLAG_C];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mul_pc        <= '0;
            stall         <= 1'b0;
            flush         <= 1'b0;
            branch_target <= '0;
            res_valid     <= 1'b0;
            result        <= '0;
            opcode_out    <= '0;
            pc_out        <= '0;
            flags         <= '0;
        end else begin
            flush     <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        state  <= MUL_BUSY;
                        stall  <= 1'b1;
                        mul_pc <= pc_in;
                    end else if (accept) begin
                        res_valid  <= 1'b1;
                        result     <= alu_res;
                        opcode_out <= opcode;
                        pc_out     <= pc_in;
                        if (upd_flags) begin
                            flags[FLAG_N] <= alu_res[DATA_W-1];
                            flags[FLAG_C] <= alu_c;
                            flags[FLAG_Z] <= (alu_res == '0);
                        end
                        if (taken) begin
                            flush         <= 1'b1;
                            branch_target <= op1;
                        end
                    end
                end
                MUL_BUSY: begin
                    if (mul_done) begin
                        state         <= IDLE;
                        stall         <= 1'b0;
                        res_valid     <= 1'b1;
                        result        <= product[DATA_W-1:0];
                        opcode_out    <= OP_MUL;
                        pc_out        <= mul_pc;
                        flags[FLAG_N] <= product[DATA_W-1];
                        flags[FLAG_C] <= (product[2*DATA_W-1:DATA_W] != '0);
                        flags[FLAG_Z] <= (product[DATA_W-1:0] == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: driver queues expected results,
// a negedge monitor pops and compares whenever res_valid is high.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] op1 = '0;
    logic [15:0] op2 = '0;
    logic [7:0]  opcode = '0;
    logic [15:0] pc_in = '0;
    logic        stall;
    logic        flush;
    logic [15:0] branch_target;
    logic        res_valid;
    logic [15:0] result;
    logic [7:0]  opcode_out;
    logic [15:0] pc_out;
    logic [2:0]  flags;

    typedef struct packed {
        logic [15:0] res;
        logic [7:0]  opc;
        logic [15:0] pc;
        logic [2:0]  flg;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;

    execute_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .op1           (op1),
        .op2           (op2),
        .opcode        (opcode),
        .pc_in         (pc_in),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .res_valid     (res_valid),
        .result        (result),
        .opcode_out    (opcode_out),
        .pc_out        (pc_out),
        .flags         (flags)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_result got res=%h opc=%h pc=%h flg=%b want none",
                         result, opcode_out, pc_out, flags);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({result, opcode_out, pc_out, flags} !== e) begin
                    mismatched++;
                    $display("FAIL result_pc%h got res=%h opc=%h pc=%h flg=%b want res=%h opc=%h pc=%h flg=%b",
                             e.pc, result, opcode_out, pc_out, flags,
                             e.res, e.opc, e.pc, e.flg);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [7:0] opc, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] pc,
                         input logic push, input logic [15:0] er,
                         input logic [2:0] ef, output int stalls);
        int guard;
        guard  = 0;
        stalls = 0;
        opcode = opc;
        op1 = a;
        op2 = b;
        pc_in = pc;
        in_valid = 1'b1;
        while ((stall || flush) && guard < 60) begin
            if (stall) stalls++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 60) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout pc=%h got stalled want accepted", pc);
        end
        @(posedge clk);
        if (push) sb.push_back('{er, opc, pc, ef});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int st;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs",
              {stall, flush, branch_target, res_valid, result,
               opcode_out, pc_out, flags}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'h01, 16'hFFFF, 16'h0001, 16'h0100, 1, 16'h0000, 3'b011, st);

        issue(8'h08, 16'h0012, 16'h0034, 16'h0102, 1, 16'h03A8, 3'b000, st);
        check("mul_stall_now", {63'd0, stall}, 64'd1);
        issue(8'h02, 16'h0005, 16'h0007, 16'h0104, 1, 16'hFFFE, 3'b110, st);
        check("mul1_stall_cycles", st, 64'd16);

        issue(8'h08, 16'h1000, 16'h0100, 16'h0106, 1, 16'h0000, 3'b011, st);
        issue(8'h06, 16'h8001, 16'h0001, 16'h0108, 1, 16'h0002, 3'b010, st);
        check("mul2_stall_cycles", st, 64'd16);
        issue(8'h07, 16'h0003, 16'h0001, 16'h010A, 1, 16'h0001, 3'b010, st);
        issue(8'h05, 16'hA5A5, 16'hFFFF, 16'h010C, 1, 16'h5A5A, 3'b000, st);
        issue(8'h03, 16'hF0F0, 16'h8F00, 16'h010E, 1, 16'h8000, 3'b100, st);
        issue(8'h04, 16'h0000, 16'h0000, 16'h0110, 1, 16'h0000, 3'b001, st);
        issue(8'h00, 16'h1234, 16'h5678, 16'h0112, 1, 16'h0000, 3'b001, st);
        issue(8'h7F, 16'h1234, 16'h5678, 16'h0114, 1, 16'h0000, 3'b001, st);

        issue(8'h02, 16'h0003, 16'h0003, 16'h0116, 1, 16'h0000, 3'b001, st);
        issue(8'h11, 16'h0040, 16'h0000, 16'h0118, 1, 16'h0000, 3'b001, st);
        check("jz_flush", {63'd0, flush}, 64'd1);
        check("jz_target", {48'd0, branch_target}, 64'h0040);
        opcode = 8'h01;
        op1 = 16'h0001;
        op2 = 16'h0001;
        pc_in = 16'h011A;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("squash_res_valid", {63'd0, res_valid}, 64'd0);
        check("flush_one_cycle", {63'd0, flush}, 64'd0);
        check("squash_flags", {61'd0, flags}, 64'd1);

        issue(8'h12, 16'h0080, 16'h0000, 16'h011C, 1, 16'h0000, 3'b001, st);
        check("jc_not_taken", {63'd0, flush}, 64'd0);

        issue(8'h10, 16'h0200, 16'h0000, 16'h011E, 1, 16'h0000, 3'b001, st);
        check("jmp_target", {47'd0, flush, branch_target}, 64'h10200);
        @(negedge clk);

        issue(8'h08, 16'h0012, 16'h0034, 16'h0120, 0, 16'h0000, 3'b000, st);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid_mul", {62'd0, stall, res_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'h01, 16'h0002, 16'h0002, 16'h0122, 1, 16'h0004, 3'b000, st);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Stage 3 of the 16-bit pipelined processor. Consumes the operand pair, opcode and PC held in the stage-2 output buffer, executes single-cycle ALU operations, a 16-cycle shift-add multiply and conditional jumps, and registers the result into the stage-3/4 buffer. It drives a stall back to the stage-2 buffer while the multiplier is busy, and a flush to stages 1–2 on a taken jump.

## Interface
- No parameters. Data width is fixed at 16 bits and opcode width at 8 bits.
- `clk` — in, 1: single clock; all state updates on the rising edge.
- `rst_n` — in, 1: asynchronous, active-low reset.
- `in_valid` — in, 1: the stage-2 buffer holds a real instruction.
- `op1` — in, 16: operand 1 from stage-2 buffer.
- `op2` — in, 16: operand 2 from stage-2 buffer.
- `opcode` — in, 8: opcode from stage-2 buffer.
- `pc_in` — in, 16: PC of the instruction.
- `stall` — out, 1: the stage-2 buffer must hold its contents.
- `flush` — out, 1: stages 1–2 must clear; the PC loads `branch_target`.
- `branch_target` — out, 16: jump destination, valid while `flush` is 1.
- `res_valid` — out, 1: the result buffer holds a completed instruction.
- `result` — out, 16: ALU or multiply result.
- `opcode_out` — out, 8: opcode of the completed instruction.
- `pc_out` — out, 16: PC of the completed instruction.
- `flags` — out, 3: registered {N, C, Z}.

## Operation
- Opcode map:
  - `00` NOP
  - `01` ADD
  - `02` SUB (op1−op2)
  - `03` AND
  - `04` OR
  - `05` XOR
  - `06` SHL (op1 << op2[3:0])
  - `07` SHR (logical)
  - `08` MUL
  - `10` JMP
  - `11` JZ
  - `12` JC
  - Any other value executes as NOP.
- Accept condition: `in_valid && state==IDLE && !flush`.
- FSM has two states: IDLE and MUL_BUSY.
  - IDLE→MUL_BUSY on accepting MUL.
  - MUL_BUSY→IDLE when the iteration count reaches 15.
- ALU ops produce results mod 2^16.
  - C = carry-out for ADD, borrow for SUB, last bit shifted out for SHL/SHR, 0 for logic ops.
  - Z = (result==0); N = result[15].
- MUL computes the low 16 bits of op1×op2. C = (high 16 bits ≠ 0). Z and N come from the low 16 bits.
- Flags update only on completion of ALU ops and MUL. NOP, jumps and unknown opcodes leave flags unchanged.
- Jumps:
  - JMP is always taken. JZ is taken if registered Z=1; JC is taken if registered C=1.
  - Target = op1.
  - Every jump and NOP writes the result buffer with `result`=0 and `res_valid`=1, so `pc_out` stays traceable.
- Flush behaviour:
  - A taken jump sets `flush`=1 and `branch_target`=op1 for exactly one cycle.
  - While `flush`=1, the presented instruction is squashed: not accepted, no flag change, `res_valid`=0 next cycle.
- A cycle with no accept writes `res_valid`=0. `result`, `opcode_out` and `pc_out` hold their previous values.

## Timing
- Reset values: `stall`=0, `flush`=0, `branch_target`=0, `res_valid`=0, `result`=0, `opcode_out`=0, `pc_out`=0, `flags`=0, state=IDLE, counter=0.
- Single-cycle ops: accepted at edge E0; outputs are valid in the cycle after E0. Latency is 1.
- MUL timing:
  - Accepted at E0. `stall`=1 (registered) from E0 through E16, for 16 cycles.
  - Result, flags and `res_valid`=1 are written at E16. `res_valid`=0 in the cycles after E1..E15.
  - The held instruction is accepted at E17 at the earliest.
- Jump: `flush` is asserted after E0 and cleared at E1 unless another taken jump is accepted. That cannot happen, because E1 squashes the input.
- Flags read by JZ/JC are the registered values. An ALU op accepted at E0 followed by a jump accepted at E1 sees the updated flags; no bypass is needed.
- Reset mid-MUL: the operation is abandoned, `stall` drops immediately, and no result is written.
- `in_valid`=0 during IDLE: no state change except `res_valid`=0 and `flush`=0.

## Structure
- Shared package `risc_pkg` holds:
  - opcode constants (OP_NOP … OP_JC);
  - `DATA_W`=16 and `OPC_W`=8;
  - the flag bit indices `FLAG_Z`=0, `FLAG_C`=1, `FLAG_N`=2.
- Sub-module `shift_add_multiplier` contains:
  - `start`, `a`, `b` inputs;
  - a 4-bit counter and 32-bit accumulator;
  - `done`, `product[31:0]` outputs.
  - It is owned by the execute_stage FSM.
- The ALU and jump resolution stay inline as combinational logic feeding the output registers.

## Test plan
- Reset then ADD 0xFFFF+0x0001 → next cycle `result`=0x0000, `flags`={N0,C1,Z1}, `res_valid`=1, `pc_out`=`pc_in`.
- MUL 0x0012×0x0034 → `stall` high for exactly 16 cycles, then `result`=0x03A8 and C=0. The following SUB 5−7, held during the stall, yields 0xFFFE with N=1 and C=1.
- MUL 0x1000×0x0100 → `result`=0x0000, C=1, Z=1.
- SUB 3−3, then JZ op1=0x0040 → `flush` pulses once with target 0x0040. The next presented ADD is squashed: `res_valid`=0, flags unchanged.
- JC with C=0 → no flush, `res_valid`=1, `result`=0.
- Assert `rst_n`=0 at cycle 7 of a MUL → `stall`=0 and `res_valid`=0 immediately. After release, no stale MUL result appears and ADD 2+2 gives 0x0004.
